dsp_acc_drain: RTL and testbench

- Consumer-side counterpart of the registered-input multiplier test designs: the product feeds only DFFs, here an accumulator and a held result register.
- Flow: signed operand pairs stream in under a valid/ready handshake. Each pair goes through input registers, then a product register. ACC_LEN consecutive products are summed into a 64-bit sign-extended accumulator.
- The finished sum is presented on a valid/ready output port.
- Used as a pack_dsp_regs regression design: DSP input regs, output regs, and the accumulator-feedback path all present.

---
 rtl/dsp_acc_pkg.sv | 14 +
 rtl/dsp_mul_stage.sv | 46 ++++
 rtl/dsp_acc_drain.sv | 91 +++++++++
 tb/tb_dsp_acc_drain.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_acc_pkg.sv
// Shared widths and helpers for the multiply-accumulate drain design.
// The product is sign-extended into the wide accumulator without saturation.
package dsp_acc_pkg;

  localparam int A_W    = 20;
  localparam int B_W    = 18;
  localparam int ACC_W  = 64;
  localparam int PROD_W = A_W + B_W;

  function automatic logic signed [ACC_W-1:0] sign_extend(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dsp_mul_stage.sv
// Operand registers followed by a product register, both gated by a shared enable.
// The register-multiply-register shape is kept simple so it maps onto one DSP cell.
module dsp_mul_stage #(
  parameter int A_W = 20,
  parameter int B_W = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic signed [A_W-1:0]       in_a,
  input  logic signed [B_W-1:0]       in_b,
  output logic                        out_valid,
  output logic signed [A_W+B_W-1:0]   out_p
);

  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0] a_r;
  logic signed [B_W-1:0] b_r;
  logic                  v1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r       <= '0;
      b_r       <= '0;
      v1        <= 1'b0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      // Only the valid bits need flushing; stale data behind a cleared valid is harmless.
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (in_valid) begin
        a_r <= in_a;
        b_r <= in_b;
      end
      v1        <= in_valid;
      out_p     <= P_W'(a_r) * P_W'(b_r);
      out_valid <= v1;
    end
  end

endmodule

// File: rtl/dsp_acc_drain.sv
// Sums ACC_LEN consecutive signed products and presents each sum on a valid/ready port.
// A held, unaccepted result stalls the whole pipeline, including the input handshake.
module dsp_acc_drain #(
  parameter int A_W     = dsp_acc_pkg::A_W,
  parameter int B_W     = dsp_acc_pkg::B_W,
  parameter int ACC_W   = dsp_acc_pkg::ACC_W,
  parameter int ACC_LEN = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [A_W-1:0]    in_a,
  input  logic signed [B_W-1:0]    in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data
);

  import dsp_acc_pkg::*;

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  logic                    en;
  logic                    p_valid;
  logic signed [P_W-1:0]   p;
  logic signed [ACC_W-1:0] sx;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  dsp_mul_stage #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .en       (en),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(p_valid),
    .out_p    (p)
  );

  generate
    if (A_W == dsp_acc_pkg::A_W && B_W == dsp_acc_pkg::B_W && ACC_W == dsp_acc_pkg::ACC_W) begin : g_pkg_sx
      assign sx = sign_extend(p);
    end else begin : g_cast_sx
      assign sx = ACC_W'(p);
    end
  endgenerate

  // The first product of a group loads rather than adds, so acc never needs a separate clear cycle.
  assign sum = (cnt == '0) ? sx : acc + sx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (en && p_valid) begin
        if (cnt == LAST) begin
          out_data  <= sum;
          out_valid <= 1'b1;
          cnt       <= '0;
          acc       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_acc_drain.sv
// Directed and randomized checks of the accumulate-and-drain block with ACC_LEN=4.
// Inputs change 1ns after each rising edge; outputs are read away from the edge.
module tb_dsp_acc_drain;

  localparam int A_W     = 20;
  localparam int B_W     = 18;
  localparam int ACC_W   = 64;
  localparam int ACC_LEN = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   in_a;
  logic signed [B_W-1:0]   in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dsp_acc_drain #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .ACC_LEN(ACC_LEN)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives n back-to-back pairs; callers only use it while in_ready is known to be high.
  task automatic feed(input int a, input int b, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = A_W'(a);
      in_b     = B_W'(b);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    vectors++; if (out_data !== 64'sd0) begin miscompares++; $display("FAIL reset_out_data got %0d expected 0", out_data); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    feed(3, 5, 4);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early0 got %b expected 0", out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early1 got %b expected 0", out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b expected 1", out_valid); end
    vectors++; if (out_data !== 64'sd60) begin miscompares++; $display("FAIL basic_data got %0d expected 60", out_data); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse got %b expected 0", out_valid); end
    $display("test_basic done");
  endtask

  task automatic test_sign;
    out_ready = 1'b1;
    feed(-524288, -131072, 4);
    for (int i = 0; i < 6 && out_valid !== 1'b1; i++) tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sign_pos_timeout got %b expected 1", out_valid); end
    vectors++; if (out_data !== 64'sd274877906944) begin miscompares++; $display("FAIL sign_pos got %0d expected 274877906944", out_data); end
    feed(-524288, 131071, 4);
    for (int i = 0; i < 6 && out_valid !== 1'b1; i++) tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sign_neg_timeout got %b expected 1", out_valid); end
    vectors++; if (out_data !== -64'sd274875809792) begin miscompares++; $display("FAIL sign_neg got %0d expected -274875809792", out_data); end
    tick();
    $display("test_sign done");
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int held_idx;
    bit found = 0;
    bit acc;
    logic signed [ACC_W-1:0] got[$];
    out_ready = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      in_valid = (idx < 8); in_a = A_W'(idx + 1); in_b = B_W'(1);
      #1; acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      if (out_valid === 1'b1) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL bp_first_timeout got 0 expected 1"); end
    vectors++; if (out_data !== 64'sd10) begin miscompares++; $display("FAIL bp_first_data got %0d expected 10", out_data); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b expected 0", in_ready); end
    vectors++; if (idx !== 6) begin miscompares++; $display("FAIL bp_accepted got %0d expected 6", idx); end
    held_idx = idx;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 8); in_a = A_W'(idx + 1); in_b = B_W'(1);
      #1; acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      vectors++; if (out_valid !== 1'b1 || out_data !== 64'sd10 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got valid=%b data=%0d ready=%b expected 1/10/0", c, out_valid, out_data, in_ready);
      end
    end
    vectors++; if (idx !== held_idx) begin miscompares++; $display("FAIL bp_no_accept got %0d expected %0d", idx, held_idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 2; c++) begin
      in_valid = (idx < 8); in_a = A_W'(idx + 1); in_b = B_W'(1);
      #1; acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL bp_count got %0d expected 2", got.size()); end
    if (got.size() == 2) begin
      vectors++; if (got[0] !== 64'sd10) begin miscompares++; $display("FAIL bp_res0 got %0d expected 10", got[0]); end
      vectors++; if (got[1] !== 64'sd26) begin miscompares++; $display("FAIL bp_res1 got %0d expected 26", got[1]); end
    end
    vectors++; if (idx !== 8) begin miscompares++; $display("FAIL bp_total got %0d expected 8", idx); end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_clr;
    out_ready = 1'b1;
    feed(1, 1, 2);
    tick();
    tick();
    clr = 1'b1; in_valid = 1'b1; in_a = A_W'(1); in_b = B_W'(1);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL clr_in_ready got %b expected 1", in_ready); end
    tick();
    clr = 1'b0; in_valid = 1'b0;
    feed(2, 2, 4);
    for (int i = 0; i < 6 && out_valid !== 1'b1; i++) tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL clr_timeout got %b expected 1", out_valid); end
    vectors++; if (out_data !== 64'sd16) begin miscompares++; $display("FAIL clr_data got %0d expected 16", out_data); end
    tick();
    $display("test_clr done");
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    feed(1, 1, 4);
    in_valid = 1'b1; in_a = A_W'(1); in_b = B_W'(1);
    for (int i = 0; i < 6 && out_valid !== 1'b1; i++) tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 64'sd4) begin
      miscompares++; $display("FAIL rst_held got valid=%b data=%0d expected 1/4", out_valid, out_data);
    end
    tick();
    #2; reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid got %b expected 0", out_valid); end
    vectors++; if (out_data !== 64'sd0) begin miscompares++; $display("FAIL rst_async_data got %0d expected 0", out_data); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_async_ready got %b expected 1", in_ready); end
    in_valid = 1'b0;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    tick();
    feed(1, 7, 4);
    for (int i = 0; i < 6 && out_valid !== 1'b1; i++) tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 64'sd28) begin
      miscompares++; $display("FAIL rst_after got valid=%b data=%0d expected 1/28", out_valid, out_data);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random;
    localparam int N = 24;
    logic signed [A_W-1:0]   ra[N];
    logic signed [B_W-1:0]   rb[N];
    logic signed [ACC_W-1:0] exp_sum[N/ACC_LEN];
    int idx = 0;
    int nres = 0;
    bit acc;
    for (int k = 0; k < N / ACC_LEN; k++) exp_sum[k] = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = A_W'($urandom);
      rb[i] = B_W'($urandom);
      exp_sum[i / ACC_LEN] += longint'(ra[i]) * longint'(rb[i]);
    end
    for (int c = 0; c < 600 && nres < N / ACC_LEN; c++) begin
      in_valid  = (idx < N) && ($urandom_range(0, 9) < 7);
      in_a      = (idx < N) ? ra[idx] : '0;
      in_b      = (idx < N) ? rb[idx] : '0;
      out_ready = ($urandom_range(0, 9) < 6);
      #1; acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        vectors++;
        if (out_data !== exp_sum[nres]) begin
          miscompares++; $display("FAIL rand_res%0d got %0d expected %0d", nres, out_data, exp_sum[nres]);
        end
        nres++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (nres !== N / ACC_LEN) begin miscompares++; $display("FAIL rand_count got %0d expected %0d", nres, N / ACC_LEN); end
    $display("test_random done: %0d pairs, %0d results", idx, nres);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_clr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
